dma_desc_mux: RTL and testbench

- Parametrised descriptor front-end for one XDMA bypass direction (C2H or H2C); one instance per direction.
- Accepts descriptors from NUM_CH user channels, buffers each channel in its own FIFO, and arbitrates between channels round-robin.
- Splits each descriptor into chunks that do not cross a MAX_CHUNK address boundary, then drives the XDMA descriptor-bypass load/ready interface.
- Adds multi-channel sharing and transfer-size splitting to the existing single-channel pass-through bypass path.

---
 rtl/dma_desc_mux_if.sv | 36 +++
 rtl/dma_desc_mux.sv | 186 ++++++++++++++++++
 tb/tb_dma_desc_mux.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_desc_mux_if.sv
// Descriptor handshake bundle for dma_desc_mux.
//   slave  : view of the mux (user descriptor sink, XDMA bypass source)
//   master : view of the surrounding logic / bench
// Signals:
//   s_desc_valid/ready/addr/len : per-channel user descriptor input, channel i at [i*W +: W]
//   dsc_byp_ready/load/addr/len : XDMA descriptor-bypass load/ready interface
//   dsc_byp_ch                  : source channel of the current chunk
//   dsc_last                    : current chunk ends its descriptor
interface dma_desc_mux_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LEN_W  = 32
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        s_desc_valid;
  logic [NUM_CH-1:0]        s_desc_ready;
  logic [NUM_CH*ADDR_W-1:0] s_desc_addr;
  logic [NUM_CH*LEN_W-1:0]  s_desc_len;
  logic                     dsc_byp_ready;
  logic                     dsc_byp_load;
  logic [ADDR_W-1:0]        dsc_byp_addr;
  logic [LEN_W-1:0]         dsc_byp_len;
  logic [CH_W-1:0]          dsc_byp_ch;
  logic                     dsc_last;

  modport slave (
    input  s_desc_valid, s_desc_addr, s_desc_len, dsc_byp_ready,
    output s_desc_ready, dsc_byp_load, dsc_byp_addr, dsc_byp_len, dsc_byp_ch, dsc_last
  );

  modport master (
    output s_desc_valid, s_desc_addr, s_desc_len, dsc_byp_ready,
    input  s_desc_ready, dsc_byp_load, dsc_byp_addr, dsc_byp_len, dsc_byp_ch, dsc_last
  );
endinterface

// File: rtl/dma_desc_mux.sv
// Multi-channel descriptor front-end for one XDMA bypass direction.
// Each user channel feeds its own FIFO; a round-robin arbiter picks a channel, and the
// selected descriptor is split into chunks that never cross a MAX_CHUNK address boundary.
// Ports:
//   pcie_clk      : clock
//   pcie_aresetn  : asynchronous active-low reset
//   bus           : dma_desc_mux_if.slave (user descriptor inputs, XDMA bypass outputs)
//   busy          : any FIFO non-empty or a descriptor in progress
//   stat_chunks   : issued loads (only with DMA_DESC_MUX_STATS_EN)
//   stat_descs    : completed non-zero descriptors (only with DMA_DESC_MUX_STATS_EN)
// Optional feature macro: DMA_DESC_MUX_STATS_EN
module dma_desc_mux #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned LEN_W      = 32,
  parameter int unsigned MAX_CHUNK  = 4096,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           pcie_clk,
  input  logic           pcie_aresetn,
  dma_desc_mux_if.slave  bus,
  output logic           busy
`ifdef DMA_DESC_MUX_STATS_EN
  ,
  output logic [31:0]    stat_chunks,
  output logic [31:0]    stat_descs
`endif
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OFF_W = $clog2(MAX_CHUNK);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  // Per-channel FIFO storage
  logic [ADDR_W-1:0] fifo_addr_q [NUM_CH][FIFO_DEPTH];
  logic [LEN_W-1:0]  fifo_len_q  [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q    [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q    [NUM_CH];
  logic [PTR_W:0]    cnt_q       [NUM_CH];

  logic [NUM_CH-1:0] empty, full, push, pop_ch;

  state_e            state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [CH_W-1:0]   ch_q;
  logic [CH_W-1:0]   rr_ptr_q;
  // Holds ready low until the first edge after reset release.
  logic              init_q;

  logic              grant_vld;
  logic [CH_W-1:0]   grant_idx;
  logic [ADDR_W-1:0] head_addr;
  logic [LEN_W-1:0]  head_len;
  logic              pop;

  logic [LEN_W-1:0]  room, chunk;
  logic              last, load;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      empty[i] = (cnt_q[i] == '0);
      full[i]  = (cnt_q[i] == (PTR_W+1)'(FIFO_DEPTH));
    end
  end

  assign bus.s_desc_ready = init_q ? ~full : '0;
  assign push             = bus.s_desc_valid & bus.s_desc_ready;

  // Round-robin: first non-empty channel after the last granted one.
  always_comb begin
    int unsigned c;
    c         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (int'(rr_ptr_q) + k) % NUM_CH;
      if (!grant_vld && !empty[c]) begin
        grant_vld = 1'b1;
        grant_idx = CH_W'(c);
      end
    end
  end

  assign head_addr = fifo_addr_q[grant_idx][rd_ptr_q[grant_idx]];
  assign head_len  = fifo_len_q[grant_idx][rd_ptr_q[grant_idx]];
  assign pop       = (state_q == StIdle) && grant_vld;

  always_comb begin
    pop_ch = '0;
    if (pop) pop_ch[grant_idx] = 1'b1;
  end

  // Bytes left before the next MAX_CHUNK boundary.
  assign room  = LEN_W'(MAX_CHUNK) - {{(LEN_W-OFF_W){1'b0}}, cur_addr_q[OFF_W-1:0]};
  assign chunk = (rem_q < room) ? rem_q : room;
  assign last  = (state_q == StIssue) && (rem_q == chunk);
  assign load  = (state_q == StIssue) && bus.dsc_byp_ready;

  assign bus.dsc_byp_load = load;
  assign bus.dsc_byp_addr = cur_addr_q;
  assign bus.dsc_byp_len  = chunk;
  assign bus.dsc_byp_ch   = ch_q;
  assign bus.dsc_last     = last;
  assign busy             = (|(~empty)) || (state_q != StIdle);

  always_ff @(posedge pcie_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        fifo_addr_q[i][wr_ptr_q[i]] <= bus.s_desc_addr[i*ADDR_W +: ADDR_W];
        fifo_len_q[i][wr_ptr_q[i]]  <= bus.s_desc_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
    if (!pcie_aresetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i])   wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop_ch[i]) rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        cnt_q[i] <= cnt_q[i] + (PTR_W+1)'(push[i]) - (PTR_W+1)'(pop_ch[i]);
      end
    end
  end

  always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
    if (!pcie_aresetn) begin
      state_q    <= StIdle;
      cur_addr_q <= '0;
      rem_q      <= '0;
      ch_q       <= '0;
      rr_ptr_q   <= CH_W'(NUM_CH - 1);
      init_q     <= 1'b0;
    end else begin
      init_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (grant_vld) begin
            rr_ptr_q <= grant_idx;
            // Zero-length heads are dropped without a load.
            if (head_len != '0) begin
              cur_addr_q <= head_addr;
              rem_q      <= head_len;
              ch_q       <= grant_idx;
              state_q    <= StIssue;
            end
          end
        end
        StIssue: begin
          if (load) begin
            cur_addr_q <= cur_addr_q + ADDR_W'(chunk);
            rem_q      <= rem_q - chunk;
            if (last) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DMA_DESC_MUX_STATS_EN
  logic [31:0] stat_chunks_q, stat_descs_q;

  always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
    if (!pcie_aresetn) begin
      stat_chunks_q <= '0;
      stat_descs_q  <= '0;
    end else if (load) begin
      stat_chunks_q <= stat_chunks_q + 32'd1;
      if (last) stat_descs_q <= stat_descs_q + 32'd1;
    end
  end

  assign stat_chunks = stat_chunks_q;
  assign stat_descs  = stat_descs_q;
`endif

endmodule

// File: tb/tb_dma_desc_mux.sv
module tb_dma_desc_mux;
  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned LEN_W      = 32;
  localparam int unsigned MAX_CHUNK  = 4096;
  localparam int unsigned FIFO_DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
`ifdef DMA_DESC_MUX_STATS_EN
  logic [31:0] stat_chunks, stat_descs;
`endif

  always #5 clk = ~clk;

  dma_desc_mux_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  dma_desc_mux #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
    .MAX_CHUNK(MAX_CHUNK), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .pcie_clk(clk),
    .pcie_aresetn(rst_n),
    .bus(bus),
    .busy(busy)
`ifdef DMA_DESC_MUX_STATS_EN
    ,
    .stat_chunks(stat_chunks),
    .stat_descs(stat_descs)
`endif
  );

  typedef struct {
    logic [63:0] addr;
    logic [31:0] len;
    logic        last;
  } chunk_t;

  typedef struct {
    int          cyc;
    int          ch;
    logic [63:0] addr;
    logic [31:0] len;
    logic        last;
  } ld_t;

  typedef struct {
    int          ch;
    logic [63:0] addr;
    logic [31:0] len;
    int          n;
    logic [31:0] first_len;
    logic [31:0] last_len;
  } vec_t;

  chunk_t q0[$];
  chunk_t q1[$];
  ld_t    ld_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  logic [1:0] acc;
  int     active_vld = 0;
  int     active_ch = 0;
  int     n_loads = 0;
  int     n_lasts = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: split a descriptor into boundary-respecting chunks on its channel's queue.
  task automatic add_desc(input int ch, input logic [63:0] a, input logic [31:0] l);
    logic [63:0] addr;
    longint unsigned rem, room, c;
    addr = a;
    rem  = l;
    while (rem != 0) begin
      room = MAX_CHUNK - (addr % MAX_CHUNK);
      c    = (rem < room) ? rem : room;
      if (ch == 0) q0.push_back('{addr, 32'(c), rem == c});
      else         q1.push_back('{addr, 32'(c), rem == c});
      addr += c;
      rem  -= c;
    end
  endtask

  task automatic check_load();
    chunk_t e;
    int     ch;
    int     have;
    ch = int'(bus.dsc_byp_ch);
    if (active_vld != 0) check("contig_ch", 64'(ch), 64'(active_ch));
    have = (ch == 0) ? q0.size() : q1.size();
    if (have == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_load: ch %0d addr 0x%0h len 0x%0h, required no load",
               ch, bus.dsc_byp_addr, bus.dsc_byp_len);
    end else begin
      e = (ch == 0) ? q0.pop_front() : q1.pop_front();
      check("load_addr", bus.dsc_byp_addr, e.addr);
      check("load_len", 64'(bus.dsc_byp_len), 64'(e.len));
      check("load_last", 64'(bus.dsc_last), 64'(e.last));
    end
    ld_q.push_back('{cyc, ch, bus.dsc_byp_addr, bus.dsc_byp_len, bus.dsc_last});
    n_loads++;
    if (bus.dsc_last) begin
      n_lasts++;
      active_vld = 0;
    end else begin
      active_vld = 1;
      active_ch  = ch;
    end
  endtask

  // Inputs are already driven (at negedge); sample, then advance one cycle.
  task automatic step();
    #1;
    acc = bus.s_desc_valid & bus.s_desc_ready;
    for (int i = 0; i < NUM_CH; i++)
      if (acc[i]) add_desc(i, bus.s_desc_addr[i*ADDR_W +: ADDR_W], bus.s_desc_len[i*LEN_W +: LEN_W]);
    if (bus.dsc_byp_load) check_load();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input int ch, input logic v, input logic [63:0] a, input logic [31:0] l);
    bus.s_desc_valid[ch] = v;
    bus.s_desc_addr[ch*ADDR_W +: ADDR_W] = a;
    bus.s_desc_len[ch*LEN_W +: LEN_W] = l;
  endtask

  task automatic drain(input int limit);
    int n;
    bus.s_desc_valid  = '0;
    bus.dsc_byp_ready = 1'b1;
    n = 0;
    while (busy && n < limit) begin
      step();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: busy still 1 after %0d cycles, required 0", limit);
    end
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    ld_q.delete();
    active_vld = 0;
    n_loads = 0;
    n_lasts = 0;
  endtask

  task automatic do_reset();
    bus.s_desc_valid  = '0;
    bus.dsc_byp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_ready", 64'(bus.s_desc_ready), 64'(0));
    check("rst_load", 64'(bus.dsc_byp_load), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc++;
  endtask

  vec_t vecs[8];

  initial begin
    int k, n, push_cyc, nl;
    logic [63:0] a;
    logic [31:0] l;

    vecs[0] = '{0, 64'h1000,        32'h800,  1, 32'h800,  32'h800};
    vecs[1] = '{0, 64'h0F00,        32'h2200, 4, 32'h100,  32'h100};
    vecs[2] = '{1, 64'h0FFF,        32'h2,    2, 32'h1,    32'h1};
    vecs[3] = '{1, 64'h2000,        32'h1000, 1, 32'h1000, 32'h1000};
    vecs[4] = '{0, 64'h0,           32'h0,    0, 32'h0,    32'h0};
    vecs[5] = '{1, 64'h0FFC,        32'h1004, 2, 32'h4,    32'h1000};
    vecs[6] = '{0, 64'h0123,        32'h3000, 4, 32'hEDD,  32'h123};
    vecs[7] = '{1, 64'h1_FFFF_F000, 32'h1800, 2, 32'h1000, 32'h800};

    bus.s_desc_valid  = '0;
    bus.s_desc_addr   = '0;
    bus.s_desc_len    = '0;
    bus.dsc_byp_ready = 1'b0;
    @(negedge clk);
    #1;
    check("reset_ready", 64'(bus.s_desc_ready), 64'(0));
    check("reset_load", 64'(bus.dsc_byp_load), 64'(0));
    check("reset_addr", bus.dsc_byp_addr, 64'(0));
    check("reset_len", 64'(bus.dsc_byp_len), 64'(0));
    check("reset_last", 64'(bus.dsc_last), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 64'(bus.s_desc_ready), 64'(2'b11));

    // Table-driven single descriptors: chunk count, first/last size, latency, throughput.
    bus.dsc_byp_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      ld_q.delete();
      drive(vecs[v].ch, 1'b1, vecs[v].addr, vecs[v].len);
      push_cyc = cyc;
      step();
      bus.s_desc_valid = '0;
      drain(100);
      nl = ld_q.size();
      check($sformatf("vec%0d_nchunks", v), 64'(nl), 64'(vecs[v].n));
      if (nl > 0 && vecs[v].n > 0) begin
        check($sformatf("vec%0d_latency", v), 64'(ld_q[0].cyc - push_cyc), 64'(2));
        check($sformatf("vec%0d_first_len", v), 64'(ld_q[0].len), 64'(vecs[v].first_len));
        check($sformatf("vec%0d_first_addr", v), ld_q[0].addr, vecs[v].addr);
        check($sformatf("vec%0d_last_len", v), 64'(ld_q[nl-1].len), 64'(vecs[v].last_len));
        check($sformatf("vec%0d_back_to_back", v), 64'(ld_q[nl-1].cyc - ld_q[0].cyc),
              64'(nl - 1));
      end
      check($sformatf("vec%0d_model_empty", v), 64'(q0.size() + q1.size()), 64'(0));
    end

    // Round-robin from reset: ch0 first, then alternate, one idle cycle between descriptors.
    do_reset();
    bus.dsc_byp_ready = 1'b1;
    drive(0, 1'b1, 64'h0, 32'h40);
    drive(1, 1'b1, 64'h8000, 32'h40);
    step();
    drive(0, 1'b1, 64'h40, 32'h40);
    drive(1, 1'b1, 64'h8040, 32'h40);
    step();
    drain(100);
    check("rr_count", 64'(ld_q.size()), 64'(4));
    if (ld_q.size() == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("rr_ch%0d", i), 64'(ld_q[i].ch), 64'(i % 2));
      for (int i = 1; i < 4; i++)
        check($sformatf("rr_gap%0d", i), 64'(ld_q[i].cyc - ld_q[i-1].cyc), 64'(2));
    end

    // Backpressure and FIFO full on ch1.
    ld_q.delete();
    bus.dsc_byp_ready = 1'b0;
    k = 0;
    n = 0;
    while (k < 5 && n < 30) begin
      drive(1, 1'b1, 64'h10000 + 64'(k) * 64'h100, 32'h40);
      step();
      if (acc[1]) k++;
      n++;
    end
    check("bp_accepted", 64'(k), 64'(5));
    bus.s_desc_valid = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_full_ready", 64'(bus.s_desc_ready[1]), 64'(0));
      check("bp_no_load", 64'(bus.dsc_byp_load), 64'(0));
      check("bp_addr_stable", bus.dsc_byp_addr, 64'h10000);
      check("bp_len_stable", 64'(bus.dsc_byp_len), 64'h40);
      check("bp_ch_stable", 64'(bus.dsc_byp_ch), 64'(1));
      @(negedge clk);
      cyc++;
    end
    drain(200);
    check("bp_count", 64'(ld_q.size()), 64'(5));
    if (ld_q.size() == 5)
      for (int i = 0; i < 5; i++)
        check($sformatf("bp_order%0d", i), ld_q[i].addr, 64'h10000 + 64'(i) * 64'h100);

    // Zero-length descriptor followed by a real one.
    ld_q.delete();
    drive(0, 1'b1, 64'h0, 32'h0);
    step();
    drive(0, 1'b1, 64'h40, 32'h10);
    step();
    drain(100);
    check("zero_count", 64'(ld_q.size()), 64'(1));
    if (ld_q.size() == 1) begin
      check("zero_addr", ld_q[0].addr, 64'h40);
      check("zero_len", 64'(ld_q[0].len), 64'h10);
    end

    // Randomized traffic against the reference model.
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        a = {32'($urandom_range(0, 32'hFFFF)), 32'($urandom)};
        l = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom_range(1, 32'h2800));
        drive(i, 1'($urandom_range(0, 1)), a, l);
      end
      bus.dsc_byp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(2000);
    check("rand_model_empty", 64'(q0.size() + q1.size()), 64'(0));
`ifdef DMA_DESC_MUX_STATS_EN
    check("stat_chunks", 64'(stat_chunks), 64'(n_loads));
    check("stat_descs", 64'(stat_descs), 64'(n_lasts));
`endif

    // Reset in the middle of a 3-chunk descriptor.
    clear_model();
    bus.dsc_byp_ready = 1'b1;
    drive(0, 1'b1, 64'h0, 32'h3000);
    step();
    bus.s_desc_valid = '0;
    n = 0;
    while (ld_q.size() < 1 && n < 10) begin
      step();
      n++;
    end
    check("mid_first_load", 64'(ld_q.size()), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_load", 64'(bus.dsc_byp_load), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("mid_no_loads", 64'(ld_q.size()), 64'(0));
`ifdef DMA_DESC_MUX_STATS_EN
    check("mid_stat_chunks", 64'(stat_chunks), 64'(0));
    check("mid_stat_descs", 64'(stat_descs), 64'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
